// File: rtl/fcvt_sched.sv
// rtl/fcvt_sched.sv - two-requester scheduler for a shared int/float converter
//
// Grants one of two requesters round-robin, pulses the shared converter's
// reset for one cycle, runs it for CVT_LAT enabled cycles, captures the
// result and holds it until the consumer accepts it.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   req{0,1}_valid/op/data    requester operation (op 0 int->float, 1 float->int)
//   req{0,1}_ready            one-cycle accept pulse (IDLE only)
//   rsp_valid/id/data/ovf     result held until rsp_ready
//   rsp_ready                 consumer accepts result
//   cvt_rst_n/enable/x/y      drive the shared converter
//   cvt_z/cvt_ovf             converter result
//   busy                      scheduler not idle
//   err_cnt                   saturating count of accepted non-ok results

module fcvt_sched #(
  parameter int unsigned CVT_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_op,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_op,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_ovf,
  input  logic        rsp_ready,
  output logic        cvt_rst_n,
  output logic [1:0]  cvt_enable,
  output logic [31:0] cvt_x,
  output logic [31:0] cvt_y,
  input  logic [31:0] cvt_z,
  input  logic [1:0]  cvt_ovf,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(CVT_LAT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_rr;
  logic        r_op;
  logic        r_id;
  logic [3:0]  r_cnt;
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic        r_cvt_rst_n;
  logic        r_rsp_id;
  logic [31:0] r_rsp_data;
  logic [1:0]  r_rsp_ovf;
  logic [7:0]  r_err_cnt;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_last;
  logic        w_sel_op;
  logic [31:0] w_sel_data;

  assign w_last = (r_cnt == LAT_M1);

  always_comb begin
    w_next   = r_state;
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    case (r_state)
      S_IDLE: begin
        // rst gates the grant so no ready pulse escapes while reset is held
        if (rst) begin
          if (req0_valid && req1_valid) begin
            w_grant0 = ~r_rr;
            w_grant1 = r_rr;
          end else begin
            w_grant0 = req0_valid;
            w_grant1 = req1_valid;
          end
          if (req0_valid || req1_valid) begin
            w_next = S_CLR;
          end
        end
      end
      S_CLR:   w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_sel_op   = w_grant1 ? req1_op   : req0_op;
  assign w_sel_data = w_grant1 ? req1_data : req0_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_rr        <= 1'b0;
      r_op        <= 1'b0;
      r_id        <= 1'b0;
      r_cnt       <= 4'd0;
      r_x         <= 32'd0;
      r_y         <= 32'd0;
      r_cvt_rst_n <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_rsp_ovf   <= 2'b00;
      r_err_cnt   <= 8'd0;
    end else begin
      r_state     <= w_next;
      // registered so the converter sees a clean low for exactly the CLR cycle
      r_cvt_rst_n <= (w_next != S_CLR);

      // operands are latched at grant so later requester changes cannot leak in
      if (w_grant0 || w_grant1) begin
        r_id <= w_grant1;
        r_op <= w_sel_op;
        r_x  <= w_sel_op ? 32'd0 : w_sel_data;
        r_y  <= w_sel_op ? w_sel_data : 32'd0;
        r_rr <= w_grant0;
      end

      case (r_state)
        S_CLR: r_cnt <= 4'd0;
        S_RUN: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            r_rsp_id   <= r_id;
            r_rsp_data <= cvt_z;
            r_rsp_ovf  <= cvt_ovf;
          end
        end
        S_RESP: begin
          if (rsp_ready && (r_rsp_ovf != 2'b00) && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_ovf    = r_rsp_ovf;
  assign cvt_rst_n  = r_cvt_rst_n;
  assign cvt_enable = (r_state == S_RUN) ? (r_op ? 2'b10 : 2'b01) : 2'b00;
  assign cvt_x      = r_x;
  assign cvt_y      = r_y;
  assign busy       = (r_state != S_IDLE);
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_fcvt_sched.sv
// tb/tb_fcvt_sched.sv - directed self-checking bench for fcvt_sched

module tb_fcvt_sched;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0;
  logic        req0_op = 1'b0;
  logic [31:0] req0_data = 32'd0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic        req1_op = 1'b0;
  logic [31:0] req1_data = 32'd0;
  logic        req1_ready;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_ovf;
  logic        rsp_ready = 1'b1;
  logic        cvt_rst_n;
  logic [1:0]  cvt_enable;
  logic [31:0] cvt_x;
  logic [31:0] cvt_y;
  logic [31:0] cvt_z;
  logic [1:0]  cvt_ovf;
  logic        busy;
  logic [7:0]  err_cnt;

  int n_chk = 0;
  int n_err = 0;

  fcvt_sched #(.CVT_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
    .rsp_ready(rsp_ready),
    .cvt_rst_n(cvt_rst_n), .cvt_enable(cvt_enable), .cvt_x(cvt_x), .cvt_y(cvt_y),
    .cvt_z(cvt_z), .cvt_ovf(cvt_ovf),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // converter stand-in: answers only the operands this bench uses, garbage when idle
  always_comb begin
    cvt_z   = 32'hDEADBEEF;
    cvt_ovf = 2'b11;
    if (cvt_enable == 2'b01) begin
      cvt_ovf = 2'b00;
      cvt_z   = (cvt_x == 32'h1) ? 32'h3F800000 : 32'h0BADF00D;
    end else if (cvt_enable == 2'b10) begin
      case (cvt_y)
        32'h40400000: begin cvt_z = 32'h3;  cvt_ovf = 2'b00; end
        32'h7F800000: begin cvt_z = 32'h0;  cvt_ovf = 2'b11; end
        default:      begin cvt_z = 32'h55; cvt_ovf = 2'b01; end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where rsp_valid rises.
  task automatic issue(input int which, input logic op, input logic [31:0] data, input string tag);
    int n;
    if (which == 0) begin req0_valid = 1'b1; req0_op = op; req0_data = data; end
    else            begin req1_valid = 1'b1; req1_op = op; req1_data = data; end
    #1;
    check({tag, "_grant"}, {30'd0, req1_ready, req0_ready}, (which == 0) ? 32'd1 : 32'd2);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = ~req0_op; req1_op = ~req1_op;
    req0_data = ~req0_data; req1_data = ~req1_data;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check({tag, "_clr_rstn"}, {31'd0, cvt_rst_n}, 32'd0);
        check({tag, "_clr_en"}, {30'd0, cvt_enable}, 32'd0);
      end
      if (n == 2) begin
        check({tag, "_run_rstn"}, {31'd0, cvt_rst_n}, 32'd1);
        check({tag, "_run_en"}, {30'd0, cvt_enable}, op ? 32'd2 : 32'd1);
        check({tag, "_run_x"}, cvt_x, op ? 32'd0 : data);
        check({tag, "_run_y"}, cvt_y, op ? data : 32'd0);
      end
    end while (!rsp_valid && n < 40);
    check({tag, "_latency"}, n, LAT + 2);
  endtask

  task automatic finish_rsp(input string tag, input logic id, input logic [31:0] data,
                            input logic [1:0] ovf, input logic [7:0] exp_err);
    check({tag, "_id"}, {31'd0, rsp_id}, {31'd0, id});
    check({tag, "_data"}, rsp_data, data);
    check({tag, "_ovf"}, {30'd0, rsp_ovf}, {30'd0, ovf});
    @(negedge clk);
    check({tag, "_vld_drop"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_errcnt"}, {24'd0, err_cnt}, {24'd0, exp_err});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rvld"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rid"}, {31'd0, rsp_id}, 32'd0);
    check({tag, "_rdata"}, rsp_data, 32'd0);
    check({tag, "_rovf"}, {30'd0, rsp_ovf}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_err"}, {24'd0, err_cnt}, 32'd0);
    check({tag, "_crstn"}, {31'd0, cvt_rst_n}, 32'd0);
    check({tag, "_cen"}, {30'd0, cvt_enable}, 32'd0);
    check({tag, "_cx"}, cvt_x, 32'd0);
    check({tag, "_cy"}, cvt_y, 32'd0);
    check({tag, "_rdy"}, {30'd0, req1_ready, req0_ready}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] held_data;
    int cyc, g, last, seen;

    // reset state
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_rstn", {31'd0, cvt_rst_n}, 32'd1);

    // int->float 1 -> 1.0
    issue(0, 1'b0, 32'h00000001, "i2f");
    finish_rsp("i2f", 1'b0, 32'h3F800000, 2'b00, 8'd0);

    // float->int 3.0 -> 3
    issue(1, 1'b1, 32'h40400000, "f2i");
    finish_rsp("f2i", 1'b1, 32'h00000003, 2'b00, 8'd0);

    // +inf float->int twice: bad format, identical independent responses
    issue(0, 1'b1, 32'h7F800000, "inf_a");
    finish_rsp("inf_a", 1'b0, 32'h0, 2'b11, 8'd1);
    issue(0, 1'b1, 32'h7F800000, "inf_b");
    finish_rsp("inf_b", 1'b0, 32'h0, 2'b11, 8'd2);

    // consumer back-pressure for 10 cycles with another request pending
    rsp_ready = 1'b0;
    issue(1, 1'b1, 32'h40400000, "hold");
    held_data = rsp_data;
    req0_valid = 1'b1; req0_op = 1'b0; req0_data = 32'h1;
    repeat (10) begin
      @(negedge clk);
      check("hold_vld", {31'd0, rsp_valid}, 32'd1);
      check("hold_data", rsp_data, held_data);
      check("hold_id", {31'd0, rsp_id}, 32'd1);
      check("hold_busy", {31'd0, busy}, 32'd1);
      check("hold_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    finish_rsp("hold", 1'b1, 32'h3, 2'b00, 8'd2);

    // round-robin from reset with both requesters always valid
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 1'b0; req0_data = 32'h1;
    req1_valid = 1'b1; req1_op = 1'b1; req1_data = 32'h40400000;
    cyc = 0; g = 0; last = 0;
    while (g < 4 && cyc < 100) begin
      #1;
      if (req0_ready && req1_ready) check("rr_one_hot", 32'd3, 32'd1);
      if (req0_ready || req1_ready) begin
        check("rr_order", {31'd0, req1_ready}, (g % 2 == 0) ? 32'd0 : 32'd1);
        if (g > 0) check("rr_period", cyc - last, LAT + 3);
        last = cyc;
        g++;
      end
      @(negedge clk);
      cyc++;
    end
    check("rr_grants", g, 4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin @(negedge clk); cyc++; end
    check("rr_drain", {31'd0, busy}, 32'd0);

    // reset mid-RUN drops the operation
    req0_valid = 1'b1; req0_op = 1'b0; req0_data = 32'h1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrun_en", {30'd0, cvt_enable}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("midrun");
    rst = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    check("midrun_norsp", seen, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
